// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command buffer: FSM encoding, the status-clear
// command byte and the layout of the MISO status byte.
package spi_cmd_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   localparam logic [7:0] STATUS_CLEAR = 8'hFF;

   localparam int unsigned STAT_OVF   = 7;
   localparam int unsigned STAT_FERR  = 6;
   localparam int unsigned STAT_CNT_W = 5;

   // Occupancy as reported to the host: clipped to what the 5-bit field holds.
   function automatic logic [STAT_CNT_W-1:0] sat_count(input int unsigned n);
      logic [STAT_CNT_W-1:0] r;
      if (n > 31) r = '1;
      else        r = n[STAT_CNT_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/cs_sync_edge.sv
// Two-flop synchroniser for the raw SPI chip select with registered
// rise/fall pulses.
module cs_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic cs,
   output logic cs_rise,
   output logic cs_fall
);

   logic       cs_meta;
   logic       cs_sync;
   logic       cs_prev;
   logic [1:0] settle;

   // Edges are suppressed until every stage holds a real sample, so a frame
   // already open across reset is not mistaken for a new one.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_meta <= 1'b1;
         cs_sync <= 1'b1;
         cs_prev <= 1'b1;
         settle  <= '0;
         cs_rise <= 1'b0;
         cs_fall <= 1'b0;
      end else begin
         cs_meta <= cs;
         cs_sync <= cs_meta;
         cs_prev <= cs_sync;
         if (settle != 2'd3) settle <= settle + 2'd1;
         cs_rise <= (settle == 2'd3) &&  cs_sync && !cs_prev;
         cs_fall <= (settle == 2'd3) && !cs_sync &&  cs_prev;
      end
   end

endmodule

// File: rtl/spi_cmd_fifo.sv
// Frame-aware command buffer: SPI bytes are staged tentatively and become
// visible to the engine only when chip select closes a complete frame.
module spi_cmd_fifo
   import spi_cmd_pkg::*;
#(
   parameter int depth       = 32,
   parameter int count_width = $clog2(depth) + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cs,
   input  logic [7:0]             in_byte,
   input  logic                   in_valid,
   output logic [7:0]             out_byte,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [count_width-1:0] fifo_count,
   output logic                   overflow,
   output logic [7:0]             miso_byte
);

   localparam int unsigned            AW      = $clog2(depth);
   localparam logic [count_width-1:0] DEPTH_C = count_width'(depth);
   localparam logic [count_width-1:0] ONE_C   = count_width'(1);

   logic                   cs_rise;
   logic                   cs_fall;

   logic [1:0]             state, state_n;
   logic [count_width-1:0] rd_ptr, rd_ptr_n;
   logic [count_width-1:0] commit_ptr, commit_ptr_n;
   logic [count_width-1:0] wr_ptr, wr_ptr_n;
   logic                   overflow_n;
   logic                   frame_err, frame_err_n;
   logic [7:0]             first_byte, first_byte_n;
   logic                   wr_en;
   logic                   rd_fire;
   logic                   space_ok;
   logic [7:0]             status_n;

   logic [7:0]             mem [depth];

   cs_sync_edge u_cs_sync (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .cs_rise (cs_rise),
      .cs_fall (cs_fall)
   );

   assign rd_fire  = out_valid && out_ready;
   assign space_ok = (wr_ptr - rd_ptr) < DEPTH_C;

   always_comb begin
      state_n      = state;
      wr_ptr_n     = wr_ptr;
      commit_ptr_n = commit_ptr;
      overflow_n   = overflow;
      frame_err_n  = frame_err;
      first_byte_n = first_byte;
      wr_en        = 1'b0;
      rd_ptr_n     = rd_fire ? rd_ptr + ONE_C : rd_ptr;

      case (state)
         ST_IDLE: begin
            if (in_valid) frame_err_n = 1'b1;
            if (cs_fall) begin
               state_n  = ST_RECV;
               wr_ptr_n = commit_ptr;
            end
         end
         ST_RECV: begin
            if (cs_rise) begin
               state_n = ST_IDLE;
               // A lone 0xFF is a host command, not engine data: discard it.
               if ((wr_ptr - commit_ptr) == ONE_C && first_byte == STATUS_CLEAR) begin
                  wr_ptr_n    = commit_ptr;
                  overflow_n  = 1'b0;
                  frame_err_n = 1'b0;
               end else begin
                  commit_ptr_n = wr_ptr;
               end
            end else if (in_valid) begin
               if (space_ok) begin
                  wr_en    = 1'b1;
                  wr_ptr_n = wr_ptr + ONE_C;
                  if (wr_ptr == commit_ptr) first_byte_n = in_byte;
               end else begin
                  state_n    = ST_DROP;
                  overflow_n = 1'b1;
               end
            end
         end
         ST_DROP: begin
            if (cs_rise) begin
               state_n  = ST_IDLE;
               wr_ptr_n = commit_ptr;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      status_n                   = '0;
      status_n[STAT_OVF]         = overflow;
      status_n[STAT_FERR]        = frame_err;
      status_n[STAT_CNT_W-1:0]   = sat_count(32'(fifo_count));
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= in_byte;
   end

   // Reading at the next head address keeps out_byte show-ahead at full rate.
   always_ff @(posedge clk) begin
      if (reset) out_byte <= '0;
      else       out_byte <= mem[rd_ptr_n[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         rd_ptr     <= '0;
         commit_ptr <= '0;
         wr_ptr     <= '0;
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
         first_byte <= '0;
         out_valid  <= 1'b0;
         fifo_count <= '0;
         miso_byte  <= '0;
      end else begin
         state      <= state_n;
         rd_ptr     <= rd_ptr_n;
         commit_ptr <= commit_ptr_n;
         wr_ptr     <= wr_ptr_n;
         overflow   <= overflow_n;
         frame_err  <= frame_err_n;
         first_byte <= first_byte_n;
         out_valid  <= (rd_ptr_n != commit_ptr_n);
         fifo_count <= commit_ptr_n - rd_ptr_n;
         miso_byte  <= status_n;
      end
   end

endmodule
